// File: rtl/serial_frame_rx_if.sv
// Consumer-side bundle of the framed serial receiver: parallel word, valid/ready
// handshake and the one-cycle error pulses.
interface serial_frame_rx_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             frame_err;
  logic             parity_err;
  logic             overrun;

  modport master (
    output dout, dout_valid, frame_err, parity_err, overrun,
    input  dout_ready
  );

  modport slave (
    input  dout, dout_valid, frame_err, parity_err, overrun,
    output dout_ready
  );
endinterface

// File: rtl/serial_frame_rx.sv
// Framed serial receiver: start bit, WIDTH data bits LSB first, optional even
// parity, stop bit; recovered words are offered through a one-word holding register.
module serial_frame_rx #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned PARITY_EN = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  serial_frame_rx_if.master rx
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [WIDTH-1:0] dout_q, dout_nxt;
  logic [WIDTH:0]   shift_in;
  logic             par_bad, par_bad_nxt;
  logic             valid_q, valid_nxt;
  logic             ferr_q, ferr_nxt;
  logic             perr_q, perr_nxt;
  logic             ovr_q, ovr_nxt;

  // New bit enters at the MSB; after WIDTH shifts the first bit lands in bit 0.
  assign shift_in = {din, shreg};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      shreg   <= '0;
      par_bad <= 1'b0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      shreg   <= shreg_nxt;
      par_bad <= par_bad_nxt;
      dout_q  <= dout_nxt;
      valid_q <= valid_nxt;
      ferr_q  <= ferr_nxt;
      perr_q  <= perr_nxt;
      ovr_q   <= ovr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    shreg_nxt   = shreg;
    par_bad_nxt = par_bad;
    dout_nxt    = dout_q;
    valid_nxt   = valid_q & ~rx.dout_ready;
    ferr_nxt    = 1'b0;
    perr_nxt    = 1'b0;
    ovr_nxt     = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (!din) begin
          state_nxt   = S_DATA;
          cnt_nxt     = '0;
          par_bad_nxt = 1'b0;
        end
      end
      S_DATA: begin
        shreg_nxt = shift_in[WIDTH:1];
        cnt_nxt   = cnt + CNT_W'(1);
        if (cnt == CNT_W'(WIDTH - 1)) begin
          state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        par_bad_nxt = ^shift_in;
        state_nxt   = S_STOP;
      end
      S_STOP: begin
        if (din) begin
          state_nxt = S_IDLE;
          if (par_bad) begin
            perr_nxt = 1'b1;
          end else if (!valid_q || rx.dout_ready) begin
            dout_nxt  = shreg;
            valid_nxt = 1'b1;
          end else begin
            ovr_nxt = 1'b1;
          end
        end else begin
          // A low stop bit also reports a bad parity seen in the same frame.
          state_nxt = S_BREAK;
          ferr_nxt  = 1'b1;
          perr_nxt  = par_bad;
        end
      end
      S_BREAK: begin
        if (din) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign rx.dout       = dout_q;
  assign rx.dout_valid = valid_q;
  assign rx.frame_err  = ferr_q;
  assign rx.parity_err = perr_q;
  assign rx.overrun    = ovr_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: directed frames into a plain and a parity instance,
// expected words/error pulses queued at stimulus time and popped by a monitor.
module tb_serial_frame_rx;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst;
  logic din0, din1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  typedef struct {
    logic [W-1:0] data;
    int           cyc;
  } exp_t;

  exp_t       wq0[$];
  exp_t       wq1[$];
  logic [2:0] eq0[$];
  logic [2:0] eq1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_frame_rx_if #(.WIDTH(W)) if0 ();
  serial_frame_rx_if #(.WIDTH(W)) if1 ();

  serial_frame_rx #(.WIDTH(W), .PARITY_EN(0)) u_rx0 (
    .clk (clk),
    .rst (rst),
    .din (din0),
    .rx  (if0.master)
  );

  serial_frame_rx #(.WIDTH(W), .PARITY_EN(1)) u_rx1 (
    .clk (clk),
    .rst (rst),
    .din (din1),
    .rx  (if1.master)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    tests++;
    fails++;
    $display("FAIL %s: got 0x%0h with nothing expected (cycle %0d)", name, act, cyc);
  endtask

  // Monitor body for one receiver; pops on every handshake and every error pulse.
  task automatic mon(input int id, input logic v, input logic r, input logic [W-1:0] d,
                     input logic [2:0] e);
    exp_t       x;
    logic [2:0] ec;
    if (v && r) begin
      if ((id == 0 && wq0.size() == 0) || (id == 1 && wq1.size() == 0)) begin
        unexpected($sformatf("word%0d", id), 32'(d));
      end else begin
        x = (id == 0) ? wq0.pop_front() : wq1.pop_front();
        chk($sformatf("word%0d", id), 32'(d), 32'(x.data));
        if (x.cyc >= 0) chk($sformatf("latency%0d", id), 32'(cyc), 32'(x.cyc));
      end
    end
    if (e != 3'b000) begin
      if ((id == 0 && eq0.size() == 0) || (id == 1 && eq1.size() == 0)) begin
        unexpected($sformatf("errpulse%0d", id), 32'(e));
      end else begin
        ec = (id == 0) ? eq0.pop_front() : eq1.pop_front();
        chk($sformatf("errpulse%0d", id), 32'(e), 32'(ec));
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      mon(0, if0.dout_valid, if0.dout_ready, if0.dout,
          {if0.overrun, if0.parity_err, if0.frame_err});
      mon(1, if1.dout_valid, if1.dout_ready, if1.dout,
          {if1.overrun, if1.parity_err, if1.frame_err});
    end
  end

  task automatic drive(input int id, input logic b);
    @(posedge clk);
    #1;
    if (id == 0) din0 = b;
    else         din1 = b;
  endtask

  task automatic idle(input int id, input int n);
    for (int i = 0; i < n; i++) drive(id, 1'b1);
  endtask

  // ec = {overrun, parity_err, frame_err} expected at this frame's stop bit.
  task automatic frame(input int id, input logic [W-1:0] d, input logic par, input logic stop,
                       input bit push_w, input bit lat, input logic [2:0] ec);
    exp_t x;
    int   k;
    @(posedge clk);
    #1;
    k = cyc;
    if (id == 0) din0 = 1'b0;
    else         din1 = 1'b0;
    x.data = d;
    x.cyc  = lat ? (k + int'(W) + id + 2) : -1;
    if (push_w) begin
      if (id == 0) wq0.push_back(x);
      else         wq1.push_back(x);
    end
    if (ec != 3'b000) begin
      if (id == 0) eq0.push_back(ec);
      else         eq1.push_back(ec);
    end
    for (int i = 0; i < int'(W); i++) drive(id, d[i]);
    if (id == 1) drive(id, par);
    drive(id, stop);
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_dout0"}, 32'(if0.dout), 32'h0);
    chk({tag, "_valid0"}, 32'(if0.dout_valid), 32'h0);
    chk({tag, "_errs0"}, 32'({if0.overrun, if0.parity_err, if0.frame_err}), 32'h0);
    chk({tag, "_dout1"}, 32'(if1.dout), 32'h0);
    chk({tag, "_valid1"}, 32'(if1.dout_valid), 32'h0);
    chk({tag, "_errs1"}, 32'({if1.overrun, if1.parity_err, if1.frame_err}), 32'h0);
  endtask

  initial begin
    rst = 1'b0;
    din0 = 1'b1;
    din1 = 1'b1;
    if0.dout_ready = 1'b1;
    if1.dout_ready = 1'b1;
    #12;
    chk_outs_zero("reset");
    @(posedge clk);
    #1 rst = 1'b1;

    // Single 0xA5 frame after three idle cycles.
    idle(0, 3);
    frame(0, 8'hA5, 1'b0, 1'b1, 1, 1, 3'b000);
    idle(0, 3);

    // Back-to-back frames with no idle gap.
    frame(0, 8'h3C, 1'b0, 1'b1, 1, 1, 3'b000);
    frame(0, 8'hFF, 1'b0, 1'b1, 1, 1, 3'b000);
    idle(0, 2);

    // Consumer stalled: second word overruns, first is held.
    @(posedge clk);
    #1 if0.dout_ready = 1'b0;
    frame(0, 8'h11, 1'b0, 1'b1, 1, 0, 3'b000);
    frame(0, 8'h22, 1'b0, 1'b1, 0, 0, 3'b100);
    idle(0, 2);
    chk("held_dout", 32'(if0.dout), 32'h11);
    chk("held_valid", 32'(if0.dout_valid), 32'h1);
    @(posedge clk);
    #1 if0.dout_ready = 1'b1;
    @(posedge clk);
    #1 chk("valid_drop", 32'(if0.dout_valid), 32'h0);

    // Bad stop bit, line held low, then a clean frame.
    frame(0, 8'h55, 1'b0, 1'b0, 0, 0, 3'b001);
    for (int i = 0; i < 5; i++) drive(0, 1'b0);
    drive(0, 1'b1);
    frame(0, 8'h0F, 1'b0, 1'b1, 1, 1, 3'b000);
    idle(0, 2);

    // Parity instance: good, bad parity, bad parity plus bad stop, good again.
    frame(1, 8'h07, 1'b1, 1'b1, 1, 1, 3'b000);
    idle(1, 2);
    frame(1, 8'h07, 1'b0, 1'b1, 0, 0, 3'b010);
    idle(1, 2);
    chk("perr_valid", 32'(if1.dout_valid), 32'h0);
    frame(1, 8'h07, 1'b0, 1'b0, 0, 0, 3'b011);
    idle(1, 2);
    frame(1, 8'h3C, 1'b0, 1'b1, 1, 1, 3'b000);
    idle(1, 2);

    // Async reset mid-frame while a word is held.
    @(posedge clk);
    #1 if0.dout_ready = 1'b0;
    frame(0, 8'h5A, 1'b0, 1'b1, 0, 0, 3'b000);
    idle(0, 1);
    chk("pre_rst_dout", 32'(if0.dout), 32'h5A);
    drive(0, 1'b0);
    drive(0, 1'b1);
    drive(0, 1'b0);
    drive(0, 1'b0);
    drive(0, 1'b0);
    @(posedge clk);
    #3 rst = 1'b0;
    #1 chk_outs_zero("async_rst");
    if0.dout_ready = 1'b1;
    din0 = 1'b1;
    @(posedge clk);
    #1 rst = 1'b1;
    idle(0, 2);
    frame(0, 8'h81, 1'b0, 1'b1, 1, 1, 3'b000);
    idle(0, 3);

    chk("wq0_empty", 32'(wq0.size()), 32'h0);
    chk("wq1_empty", 32'(wq1.size()), 32'h0);
    chk("eq0_empty", 32'(eq0.size()), 32'h0);
    chk("eq1_empty", 32'(eq1.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
